// File: rtl/entity_slot_scheduler_if.sv
// Request bus from the game-logic requesters into the slot scheduler.
// One valid/ready lane per requester; slot and entity fields are packed per requester.
interface entity_slot_scheduler_if #(
  parameter int NUM_REQ  = 4,
  parameter int ENTITY_W = 14
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_clear;
  logic [4*NUM_REQ-1:0]        req_slot;
  logic [ENTITY_W*NUM_REQ-1:0] req_entity;
  logic [NUM_REQ-1:0]          req_ready;

  modport master (
    output req_valid,
    output req_clear,
    output req_slot,
    output req_entity,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_clear,
    input  req_slot,
    input  req_entity,
    output req_ready
  );
endinterface

// File: rtl/entity_slot_scheduler.sv
// Round-robin writes into a shadow entity table, copied to the active table at frame start.
// Grant is combinational; entity_out lags frame_start by 2 edges; no grants during frame_start/COMMIT.
module entity_slot_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SLOTS = 9,
  parameter int ENTITY_W  = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  entity_slot_scheduler_if.slave        req_if,
  input  logic                          frame_start,
  output logic [ENTITY_W*NUM_SLOTS-1:0] entity_out,
  output logic                          commit_done,
  output logic                          drop_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ENTITY_W-1:0] EMPTY_ENT = {4'hF, {(ENTITY_W-4){1'b0}}};

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 dirty_q, dirty_d;
  logic                 commit_done_q, commit_done_d;
  logic                 drop_err_q, drop_err_d;
  logic [ENTITY_W-1:0]  shadow_q [NUM_SLOTS];
  logic [ENTITY_W-1:0]  shadow_d [NUM_SLOTS];
  logic [ENTITY_W-1:0]  active_q [NUM_SLOTS];
  logic [ENTITY_W-1:0]  active_d [NUM_SLOTS];

  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;
  logic [3:0]           sel_slot;
  logic                 sel_clear;
  logic [ENTITY_W-1:0]  sel_entity;
  logic                 sel_in_range;

  // Two passes give the rotating priority: requesters at/after rr_ptr first, then the wrap.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state_q == ST_ACCEPT && !frame_start) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && req_if.req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && req_if.req_valid[i] && (PTR_W'(i) < rr_ptr_q)) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    req_if.req_ready = '0;
    sel_slot         = '0;
    sel_clear        = 1'b0;
    sel_entity       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_idx == PTR_W'(i)) begin
        req_if.req_ready[i] = 1'b1;
        sel_slot            = req_if.req_slot[4*i +: 4];
        sel_clear           = req_if.req_clear[i];
        sel_entity          = req_if.req_entity[ENTITY_W*i +: ENTITY_W];
      end
    end
    sel_in_range = (sel_slot < 4'(NUM_SLOTS));
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    dirty_d       = dirty_q;
    commit_done_d = 1'b0;
    drop_err_d    = 1'b0;
    shadow_d      = shadow_q;
    active_d      = active_q;

    case (state_q)
      ST_ACCEPT: begin
        if (frame_start) begin
          state_d = ST_COMMIT;
        end
        if (grant_vld) begin
          rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
          if (sel_in_range) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
              if (sel_slot == 4'(s)) begin
                shadow_d[s] = sel_clear ? EMPTY_ENT : sel_entity;
              end
            end
            dirty_d = 1'b1;
          end else begin
            drop_err_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_ACCEPT;
        // A frame with no writes leaves the active table and commit_done untouched.
        if (dirty_q) begin
          active_d      = shadow_q;
          dirty_d       = 1'b0;
          commit_done_d = 1'b1;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ACCEPT;
      rr_ptr_q      <= '0;
      dirty_q       <= 1'b0;
      commit_done_q <= 1'b0;
      drop_err_q    <= 1'b0;
      shadow_q      <= '{default: EMPTY_ENT};
      active_q      <= '{default: EMPTY_ENT};
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      dirty_q       <= dirty_d;
      commit_done_q <= commit_done_d;
      drop_err_q    <= drop_err_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  always_comb begin
    entity_out = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      entity_out[ENTITY_W*s +: ENTITY_W] = active_q[s];
    end
  end

  assign commit_done = commit_done_q;
  assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_entity_slot_scheduler.sv
// Directed bench for entity_slot_scheduler: reset, commit timing, round-robin, frame collision,
// clear / out-of-range handling and mid-operation reset.
`timescale 1ns/1ps
module tb_entity_slot_scheduler;
  localparam int NR = 4;
  localparam int NS = 9;
  localparam int EW = 14;
  localparam logic [EW-1:0] EMPTY = 14'h3C00;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic [EW*NS-1:0] entity_out;
  logic             commit_done;
  logic             drop_err;
  logic [EW*NS-1:0] exp_tbl;
  int               n_checks = 0;
  int               n_fail = 0;

  entity_slot_scheduler_if #(.NUM_REQ(NR), .ENTITY_W(EW)) rif ();

  entity_slot_scheduler #(.NUM_REQ(NR), .NUM_SLOTS(NS), .ENTITY_W(EW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (rif.slave),
    .frame_start (frame_start),
    .entity_out  (entity_out),
    .commit_done (commit_done),
    .drop_err    (drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    rif.req_valid  = '0;
    rif.req_clear  = '0;
    rif.req_slot   = '0;
    rif.req_entity = '0;
    frame_start    = 1'b0;
  endtask

  task automatic set_req(input int r, input logic [3:0] slot, input logic [EW-1:0] ent,
                         input logic clr);
    rif.req_slot[4*r +: 4]     = slot;
    rif.req_entity[EW*r +: EW] = ent;
    rif.req_clear[r]           = clr;
    rif.req_valid[r]           = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // frame_start for one cycle; returns just after the edge where the active table updates.
  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input int r, input logic [3:0] slot, input logic [EW-1:0] ent,
                          input logic clr);
    bit got;
    got = 1'b0;
    set_req(r, slot, ent, clr);
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (rif.req_ready[r]) got = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!got) begin
      $display("FAIL write_grant_timeout: req%0d got no ready within 20 cycles", r);
      n_fail++;
    end
    @(negedge clk);
    rif.req_valid[r] = 1'b0;
    rif.req_clear[r] = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_tbl = {NS{EMPTY}};
    n_checks++;
    if (entity_out !== exp_tbl) begin
      $display("FAIL reset_table: got %h exp %h", entity_out, exp_tbl); n_fail++;
    end
    n_checks++;
    if (commit_done !== 1'b0) begin
      $display("FAIL reset_commit_done: got %b exp 0", commit_done); n_fail++;
    end
    n_checks++;
    if (drop_err !== 1'b0) begin
      $display("FAIL reset_drop_err: got %b exp 0", drop_err); n_fail++;
    end
    n_checks++;
    if (rif.req_ready !== 4'b0000) begin
      $display("FAIL reset_ready: got %b exp 0000", rif.req_ready); n_fail++;
    end
    pulse_frame();
    n_checks++;
    if (commit_done !== 1'b0) begin
      $display("FAIL clean_frame_commit: got %b exp 0", commit_done); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (commit_done !== 1'b0) begin
      $display("FAIL clean_frame_commit_late: got %b exp 0", commit_done); n_fail++;
    end
  endtask

  task automatic test_single_write();
    set_req(0, 4'd2, 14'h1A45, 1'b0);
    #1;
    n_checks++;
    if (rif.req_ready !== 4'b0001) begin
      $display("FAIL single_ready: got %b exp 0001", rif.req_ready); n_fail++;
    end
    @(negedge clk);
    rif.req_valid[0] = 1'b0;
    n_checks++;
    if (entity_out[2*EW +: EW] !== EMPTY) begin
      $display("FAIL single_shadow_hidden: got %h exp 3c00", entity_out[2*EW +: EW]); n_fail++;
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n_checks++;
    if (entity_out[2*EW +: EW] !== EMPTY || commit_done !== 1'b0) begin
      $display("FAIL single_one_edge: slot2 %h done %b exp 3c00 0",
               entity_out[2*EW +: EW], commit_done); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (entity_out[2*EW +: EW] !== 14'h1A45) begin
      $display("FAIL single_commit_slot2: got %h exp 1a45", entity_out[2*EW +: EW]); n_fail++;
    end
    n_checks++;
    if (commit_done !== 1'b1) begin
      $display("FAIL single_commit_done: got %b exp 1", commit_done); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (commit_done !== 1'b0) begin
      $display("FAIL single_commit_done_pulse: got %b exp 0", commit_done); n_fail++;
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 4'(i), 14'(14'h0100 + i), 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (rif.req_ready !== rr_exp[c]) begin
        $display("FAIL rr_grant_%0d: got %b exp %b", c, rif.req_ready, rr_exp[c]); n_fail++;
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_collision();
    do_reset();
    set_req(1, 4'd3, 14'h2222, 1'b0);
    frame_start = 1'b1;
    #1;
    n_checks++;
    if (rif.req_ready !== 4'b0000) begin
      $display("FAIL coll_fs_ready: got %b exp 0000", rif.req_ready); n_fail++;
    end
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    n_checks++;
    if (rif.req_ready !== 4'b0000) begin
      $display("FAIL coll_commit_ready: got %b exp 0000", rif.req_ready); n_fail++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (rif.req_ready !== 4'b0010) begin
      $display("FAIL coll_late_grant: got %b exp 0010", rif.req_ready); n_fail++;
    end
    @(negedge clk);
    rif.req_valid[1] = 1'b0;
    n_checks++;
    if (entity_out[3*EW +: EW] !== EMPTY) begin
      $display("FAIL coll_not_yet: got %h exp 3c00", entity_out[3*EW +: EW]); n_fail++;
    end
    pulse_frame();
    n_checks++;
    if (entity_out[3*EW +: EW] !== 14'h2222 || commit_done !== 1'b1) begin
      $display("FAIL coll_commit: slot3 %h done %b exp 2222 1",
               entity_out[3*EW +: EW], commit_done); n_fail++;
    end
  endtask

  task automatic test_clear_oor();
    do_write(2, 4'd5, 14'h0C10, 1'b0);
    pulse_frame();
    n_checks++;
    if (entity_out[5*EW +: EW] !== 14'h0C10) begin
      $display("FAIL clr_write_slot5: got %h exp 0c10", entity_out[5*EW +: EW]); n_fail++;
    end
    do_write(2, 4'd5, 14'h3FFF, 1'b1);
    pulse_frame();
    n_checks++;
    if (entity_out[5*EW +: EW] !== EMPTY || commit_done !== 1'b1) begin
      $display("FAIL clr_cleared_slot5: slot5 %h done %b exp 3c00 1",
               entity_out[5*EW +: EW], commit_done); n_fail++;
    end
    exp_tbl = {NS{EMPTY}};
    exp_tbl[3*EW +: EW] = 14'h2222;
    set_req(3, 4'd12, 14'h1234, 1'b0);
    #1;
    n_checks++;
    if (rif.req_ready !== 4'b1000 || drop_err !== 1'b0) begin
      $display("FAIL oor_ready: ready %b drop %b exp 1000 0", rif.req_ready, drop_err); n_fail++;
    end
    @(negedge clk);
    rif.req_valid[3] = 1'b0;
    n_checks++;
    if (drop_err !== 1'b1) begin
      $display("FAIL oor_drop_pulse: got %b exp 1", drop_err); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (drop_err !== 1'b0) begin
      $display("FAIL oor_drop_once: got %b exp 0", drop_err); n_fail++;
    end
    pulse_frame();
    n_checks++;
    if (commit_done !== 1'b0 || entity_out !== exp_tbl) begin
      $display("FAIL oor_no_change: done %b table %h exp 0 %h", commit_done, entity_out, exp_tbl);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    do_write(0, 4'd7, 14'h1111, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_tbl = {NS{EMPTY}};
    n_checks++;
    if (entity_out !== exp_tbl) begin
      $display("FAIL mid_reset_table: got %h exp %h", entity_out, exp_tbl); n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_frame();
    n_checks++;
    if (commit_done !== 1'b0 || entity_out !== exp_tbl) begin
      $display("FAIL mid_reset_lost_write: done %b table %h exp 0 %h",
               commit_done, entity_out, exp_tbl); n_fail++;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_collision();
    test_clear_oor();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/entity_slot_scheduler.md
# entity_slot_scheduler

Arbitrates entity updates from several game-logic requesters into a 9-slot entity table that drives the frame buffer's entity channels. Updates go into a shadow table through a valid/ready handshake with round-robin arbitration. The shadow table is copied to the active table only at frame boundaries, so the frame buffer never renders a half-updated scene. The block sits between the game logic and the frame buffer's entity inputs, which expect 4'hF as the ID of an unused slot.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- NUM_SLOTS, 9, entity slots in the table (1..15)
- ENTITY_W, 14, entity word: [13:10] ID, [9:8] orientation, [7:0] tile location
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester update request
- req_clear  in  NUM_REQ  request frees the slot instead of writing req_entity
- req_slot  in  4*NUM_REQ  target slot index; requester i uses bits [4i+3:4i]
- req_entity  in  ENTITY_W*NUM_REQ  entity word; requester i uses its own ENTITY_W slice
- req_ready  out  NUM_REQ  one-hot grant (transfer completes when valid & ready)
- frame_start  in  1  single-cycle pulse at start of vertical blanking
- entity_out  out  ENTITY_W*NUM_SLOTS  active table; slot s in bits [ENTITY_W*s +: ENTITY_W]
- commit_done  out  1  one-cycle pulse after the active table updates
- drop_err  out  1  one-cycle pulse when an out-of-range request is discarded

## Operation
- **Reset:**
  - Shadow and active slots = {4'hF, 2'b00, 8'h00}.
  - rr_ptr = 0, state = ACCEPT, dirty = 0.
  - commit_done = 0, drop_err = 0, req_ready = 0.
- **State machine:** ACCEPT and COMMIT.
  - ACCEPT → COMMIT when frame_start = 1.
  - COMMIT → ACCEPT unconditionally after one cycle.
- **Arbitration (ACCEPT only):**
  - req_ready is combinational from state, frame_start, req_valid and rr_ptr.
  - Grant the first requester with req_valid = 1, searching i = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - At most one grant per cycle.
  - After a grant to requester g, rr_ptr ← (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- **Grant suppression:** req_ready = 0 in COMMIT, and in any ACCEPT cycle with frame_start = 1. frame_start wins over a simultaneous request.
- **Requester rule:** a requester holds valid, slot, clear and entity stable until it sees ready. Deasserting valid before ready is allowed; nothing is written.
- **Write on transfer, when req_slot < NUM_SLOTS:**
  - clear = 0: shadow[slot] ← req_entity.
  - clear = 1: shadow[slot] ← {4'hF, 10'h000}.
  - Either case sets dirty = 1.
- **Out-of-range slot (req_slot ≥ NUM_SLOTS):**
  - Still handshaken (ready = 1), so the requester is not stalled.
  - Nothing is written; drop_err pulses the next cycle.
- **COMMIT cycle:**
  - If dirty: active ← shadow, dirty ← 0, commit_done pulses the next cycle.
  - If not dirty: no copy and no pulse.
- **Overwrites:** the last write to a slot before a commit wins. Multiple writes per frame are allowed.
- **frame_start in COMMIT:** ignored.
- **Reset mid-operation:** asynchronously returns every register to its reset values. Pending requests are lost, and requesters re-present them after reset.

## Timing
- Transfer at edge E (valid & ready sampled). The shadow slot holds the new value after E. It does not affect entity_out until a commit.
- frame_start high in the cycle before edge E0:
  - State is COMMIT after E0.
  - entity_out updates at E1.
  - commit_done is high for the cycle between E1 and E2.
- Worst-case grant latency for a continuously valid requester:
  - NUM_REQ cycles of ACCEPT.
  - Plus 2 cycles for each intervening frame_start (the frame_start cycle and the COMMIT cycle).
- drop_err is registered: high for exactly the cycle after the discarding transfer.
- entity_out and commit_done are registered. No combinational path runs from inputs to entity_out.

## Test plan
- **Reset:** release rst_n without requests. Every entity_out slot = 14'h3C00, commit_done = 0, drop_err = 0, req_ready = 0. A frame_start then produces no commit_done pulse.
- **Single write and commit:**
  - Req0 writes slot 2 = 14'h1A45; entity_out slot 2 stays 14'h3C00.
  - Pulse frame_start; slot 2 = 14'h1A45 exactly 2 edges later, with commit_done high for one cycle.
- **Round-robin:** req0..req3 all held valid. Grants go 0, 1, 2, 3, 0 on consecutive cycles, never two bits set.
- **Collision with frame boundary:**
  - Req1 valid in the same cycle as frame_start: ready = 0 in that cycle and in the COMMIT cycle.
  - The grant comes on the following cycle, and the write appears only after the next frame_start.
- **Clear and out-of-range:**
  - Req2 writes slot 5 = 14'h0C10, commit, then req_clear on slot 5 and commit. Slot 5 returns to 14'h3C00.
  - Req3 targets slot 12: it receives ready, drop_err pulses once, and no slot changes.
- **Reset mid-operation:** assert rst_n low between a write and its commit. The table returns to all 14'h3C00 and the write never appears.
